exe_stage_param: RTL and testbench
==================================

Name: exe_stage_param

Overview:
Parameterised execute stage for the BatPU pipeline. It sits between decode/register-read and writeback and has the same role as the fixed 8-bit execute stage: operand buffering, writeback forwarding, ALU, flags, branch/jump resolution and the call stack. It adds configurable data, PC and register-address widths, and a configurable call-stack depth with overflow/underflow detection. It also adds a memory ready/stall handshake and an add-with-carry ALU op.

Parameters:
DATA_W, 8, datapath width (>=4)
REG_AW, 4, register address width
PC_W, 10, program counter / jump target width
CS_DEPTH, 16, call-stack entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  pipeline advance enable
flush  in  1  synchronous bubble insert: captures zeros instead of inputs
rs1, rs2  in  DATA_W  register-file read data
rs1_addr, rs2_addr  in  REG_AW  source register addresses
imm  in  DATA_W  immediate, already sign-extended by decode
target  in  PC_W  jump/branch target
cond  in  2  [1]=select carry(1)/zero(0), [0]=invert
pc_in  in  PC_W  return address pushed on CALL
ctr_word_in  in  18  control word (layout below)
wb_we  in  1  writeback write enable (forwarding source)
wb_addr  in  REG_AW  writeback destination
wb_data  in  DATA_W  writeback data
mem_ready  in  1  memory accepted/completed the request this cycle
alu_res  out  DATA_W  ALU result
to_memory  out  DATA_W  store data (forwarded rs2)
mem_req, mem_we  out  1  memory request / write strobe
stall  out  1  freeze upstream stages
jmp  out  1  redirect PC
to_pc  out  PC_W  redirect target
ctr_word_to_writeback  out  5  ctr_word[17:13]
cs_overflow, cs_underflow  out  1  sticky call-stack error flags

Behaviour:
- Control word fields:
  - [2:0] alu_op; [3] bsel (0 = rs2, 1 = imm); [4] reserved; [5] flags_updt; [6] jmp; [7] brh.
  - [8] cs_exe; [9] cs_pop (0 = push); [10] pc_sel (0 = target, 1 = stack top); [11] memreq; [12] memwe; [17:13] writeback control.
- Reset (rst_n low, asynchronous):
  - All buffers, flags, stack pointer, stack contents and sticky flags go to 0.
  - Consequently every output is 0, including to_pc and stall.
- Capture register:
  - Updates on posedge when clk_en && !stall.
  - Loads zeros if flush, else loads the inputs.
  - Zero control word = bubble: no side effects.
- Forwarding, per operand: if wb_we and wb_addr equals the buffered source address, use wb_data (0 if wb_addr==0); otherwise use the buffered value.
- ALU (combinational, DATA_W wide):
  - 0 ADD; 1 SUB (carry = no borrow, i.e. a>=b unsigned); 2 NOR; 3 AND; 4 XOR.
  - 5 RSH: logical shift right by 1, carry = shifted-out bit.
  - 6 PASS b.
  - 7 ADC: a+b+carry flag.
  - Logical ops: carry = 0.
  - zero = (res==0).
- Flags {C,Z} update on posedge when clk_en && !stall && flags_updt.
- Memory handshake:
  - mem_req = memreq && clk_en && !flush; mem_we = memwe && mem_req.
  - stall = mem_req && !mem_ready (combinational).
  - While stalled: buffers hold, flags/stack do not change, jmp forced 0, ctr_word_to_writeback forced 0.
  - mem_req/mem_we stay asserted with stable to_memory until mem_ready is seen.
- Branch:
  - taken = (cond[1] ? C : Z) ^ cond[0].
  - jmp = (ctr jmp || (brh && taken)) && !stall.
  - to_pc = pc_sel ? stack top : target.
- Call stack (LIFO, CS_DEPTH entries, pointer width log2(CS_DEPTH)+1):
  - Acts on posedge when cs_exe && clk_en && !stall.
  - Push writes the buffered pc_in.
  - Pop: to_pc shows the pre-pop top in the same cycle; the pointer decrements at the edge.
  - Push when full: overwrite oldest (circular), count stays CS_DEPTH, set cs_overflow.
  - Pop when empty: top reads 0, pointer unchanged, set cs_underflow.
  - Sticky flags clear only on reset.
- flush asserted while stalled has no effect until the stall clears (the capture is blocked).

Test Plan:
- Forwarding: rs1=0x05 buffered, wb_we=1, wb_addr=rs1_addr=3, wb_data=0x2A, ADD imm 0x01 -> alu_res=0x2B. Same with wb_addr=0 -> alu_res=0x01.
- ADC chain: ADD 0xFF+0x01 with flags_updt -> res 0x00, C=1, Z=1. Next ADC 0x10+0x00 -> 0x11.
- Branch: Z=1, brh with cond=00 -> jmp=1, to_pc=target. cond=01 -> jmp=0. cond=10 with C=0 -> jmp=0.
- Memory stall: memreq=1, mem_ready=0 for 3 cycles -> stall=1 and mem_req held for 3 cycles, jmp=0, writeback ctrl=0. mem_ready=1 -> stall=0, next instruction captured.
- Call stack, CS_DEPTH=4: push 0x001..0x005 -> cs_overflow=1. Pops return 0x005,0x004,0x003,0x002. Fifth pop -> to_pc=0, cs_underflow=1.
- Reset mid-stall: assert rst_n=0 asynchronously while stalled -> all outputs 0 immediately. After release: flags 0, stack empty.

Source files
------------

// File: rtl/exe_stage_param.sv
// Parameterised BatPU execute stage: operand capture, writeback forwarding, ALU,
// flags, branch resolution, a circular call stack and a memory stall handshake.
module exe_stage_param #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 4,
    parameter int PC_W     = 10,
    parameter int CS_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [DATA_W-1:0] imm,
    input  logic [PC_W-1:0]   target,
    input  logic [1:0]        cond,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [17:0]       ctr_word_in,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] to_memory,
    output logic              mem_req,
    output logic              mem_we,
    output logic              stall,
    output logic              jmp,
    output logic [PC_W-1:0]   to_pc,
    output logic [4:0]        ctr_word_to_writeback,
    output logic              cs_overflow,
    output logic              cs_underflow
);

    localparam int IDX_W = $clog2(CS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [DATA_W-1:0] q_rs1, q_rs2, q_imm;
    logic [REG_AW-1:0] q_rs1_addr, q_rs2_addr;
    logic [PC_W-1:0]   q_target, q_pc;
    logic [1:0]        q_cond;
    logic [17:0]       q_ctr;

    logic              flag_c, flag_z;

    logic [PC_W-1:0]   cs_mem [CS_DEPTH];
    logic [IDX_W-1:0]  cs_wp;
    logic [SP_W-1:0]   cs_cnt;

    logic [DATA_W-1:0] op_a, fwd_b, op_b;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] res;
    logic              carry;
    logic              advance;
    logic              taken;
    logic              cs_empty, cs_full;
    logic [PC_W-1:0]   cs_top;
    logic              unused_reserved;

    // Control word fields of the buffered instruction.
    logic [2:0] c_op;
    logic       c_bsel, c_flags, c_jmp, c_brh, c_cs, c_pop, c_pcsel, c_memreq, c_memwe;

    assign c_op     = q_ctr[2:0];
    assign c_bsel   = q_ctr[3];
    assign c_flags  = q_ctr[5];
    assign c_jmp    = q_ctr[6];
    assign c_brh    = q_ctr[7];
    assign c_cs     = q_ctr[8];
    assign c_pop    = q_ctr[9];
    assign c_pcsel  = q_ctr[10];
    assign c_memreq = q_ctr[11];
    assign c_memwe  = q_ctr[12];
    assign unused_reserved = q_ctr[4];

    // Register 0 always reads as zero, even when it is the writeback target.
    assign op_a  = (wb_we && wb_addr == q_rs1_addr) ? ((wb_addr == '0) ? '0 : wb_data) : q_rs1;
    assign fwd_b = (wb_we && wb_addr == q_rs2_addr) ? ((wb_addr == '0) ? '0 : wb_data) : q_rs2;
    assign op_b  = c_bsel ? q_imm : fwd_b;

    always_comb begin
        alu_sum = '0;
        res     = '0;
        carry   = 1'b0;
        case (c_op)
            3'd0: begin
                alu_sum = {1'b0, op_a} + {1'b0, op_b};
                res     = alu_sum[DATA_W-1:0];
                carry   = alu_sum[DATA_W];
            end
            3'd1: begin
                res   = op_a - op_b;
                carry = (op_a >= op_b);
            end
            3'd2: res = ~(op_a | op_b);
            3'd3: res = op_a & op_b;
            3'd4: res = op_a ^ op_b;
            3'd5: begin
                res   = op_a >> 1;
                carry = op_a[0];
            end
            3'd6: res = op_b;
            3'd7: begin
                alu_sum = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, flag_c};
                res     = alu_sum[DATA_W-1:0];
                carry   = alu_sum[DATA_W];
            end
        endcase
    end

    assign alu_res   = res;
    assign to_memory = fwd_b;

    assign mem_req = c_memreq && clk_en && !flush;
    assign mem_we  = c_memwe && mem_req;
    assign stall   = mem_req && !mem_ready;
    assign advance = clk_en && !stall;

    assign cs_empty = (cs_cnt == '0);
    assign cs_full  = (cs_cnt == SP_W'(CS_DEPTH));
    assign cs_top   = cs_empty ? '0 : cs_mem[cs_wp - IDX_W'(1)];

    assign taken = (q_cond[1] ? flag_c : flag_z) ^ q_cond[0];
    assign jmp   = (c_jmp || (c_brh && taken)) && !stall;
    assign to_pc = c_pcsel ? cs_top : q_target;

    assign ctr_word_to_writeback = stall ? 5'd0 : q_ctr[17:13];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_rs1      <= '0;
            q_rs2      <= '0;
            q_imm      <= '0;
            q_rs1_addr <= '0;
            q_rs2_addr <= '0;
            q_target   <= '0;
            q_pc       <= '0;
            q_cond     <= '0;
            q_ctr      <= '0;
        end else if (advance) begin
            q_rs1      <= flush ? '0 : rs1;
            q_rs2      <= flush ? '0 : rs2;
            q_imm      <= flush ? '0 : imm;
            q_rs1_addr <= flush ? '0 : rs1_addr;
            q_rs2_addr <= flush ? '0 : rs2_addr;
            q_target   <= flush ? '0 : target;
            q_pc       <= flush ? '0 : pc_in;
            q_cond     <= flush ? '0 : cond;
            q_ctr      <= flush ? '0 : ctr_word_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (advance && c_flags) begin
            flag_c <= carry;
            flag_z <= (res == '0);
        end
    end

    // Full stack wraps and overwrites the oldest entry; empty pops leave the pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CS_DEPTH; i++) cs_mem[i] <= '0;
            cs_wp        <= '0;
            cs_cnt       <= '0;
            cs_overflow  <= 1'b0;
            cs_underflow <= 1'b0;
        end else if (advance && c_cs) begin
            if (!c_pop) begin
                cs_mem[cs_wp] <= q_pc;
                cs_wp         <= cs_wp + IDX_W'(1);
                if (cs_full) cs_overflow <= 1'b1;
                else         cs_cnt      <= cs_cnt + SP_W'(1);
            end else if (cs_empty) begin
                cs_underflow <= 1'b1;
            end else begin
                cs_wp  <= cs_wp - IDX_W'(1);
                cs_cnt <= cs_cnt - SP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exe_stage_param.sv
// Directed bench for exe_stage_param (DATA_W=8, REG_AW=4, PC_W=10, CS_DEPTH=4)
// with hand-computed expectations per scenario task.
module tb_exe_stage_param;

    logic        clk, rst_n, clk_en, flush;
    logic [7:0]  rs1, rs2, imm, wb_data;
    logic [3:0]  rs1_addr, rs2_addr, wb_addr;
    logic [9:0]  target, pc_in;
    logic [1:0]  cond;
    logic [17:0] ctr_word_in;
    logic        wb_we, mem_ready;
    logic [7:0]  alu_res, to_memory;
    logic        mem_req, mem_we, stall, jmp;
    logic [9:0]  to_pc;
    logic [4:0]  ctr_word_to_writeback;
    logic        cs_overflow, cs_underflow;

    int vectors = 0;
    int miscompares = 0;

    exe_stage_param #(.DATA_W(8), .REG_AW(4), .PC_W(10), .CS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .rs1(rs1), .rs2(rs2), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .imm(imm), .target(target), .cond(cond), .pc_in(pc_in),
        .ctr_word_in(ctr_word_in), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .mem_ready(mem_ready), .alu_res(alu_res),
        .to_memory(to_memory), .mem_req(mem_req), .mem_we(mem_we),
        .stall(stall), .jmp(jmp), .to_pc(to_pc),
        .ctr_word_to_writeback(ctr_word_to_writeback),
        .cs_overflow(cs_overflow), .cs_underflow(cs_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] cw(input logic [2:0] op, input logic bsel, fu, j, brh,
                                       cs, pop, pcsel, mreq, mwe, input logic [4:0] wb);
        cw = {wb, mwe, mreq, pcsel, pop, cs, brh, j, fu, 1'b0, bsel, op};
    endfunction

    // Present one instruction, clock it into the capture register, sample 1ns later.
    task automatic issue(input logic [17:0] c, input logic [7:0] a, input logic [3:0] aa,
                         input logic [7:0] b, input logic [3:0] ba, input logic [7:0] im,
                         input logic [9:0] tg, input logic [1:0] cd, input logic [9:0] pc);
        ctr_word_in = c; rs1 = a; rs1_addr = aa; rs2 = b; rs2_addr = ba;
        imm = im; target = tg; cond = cd; pc_in = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; mem_ready = 1'b1;
        wb_we = 1'b1; wb_addr = 4'd0; wb_data = 8'hFF;
        ctr_word_in = cw(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h1F);
        rs1 = 8'hFF; rs2 = 8'hFF; rs1_addr = 4'd0; rs2_addr = 4'd0; imm = 8'hFF;
        target = 10'h3FF; cond = 2'b00; pc_in = 10'h3FF;
        #23;
        vectors++; if (alu_res !== 8'h00) begin miscompares++; $display("FAIL reset_alu_res got %h want 00", alu_res); end
        vectors++; if (to_memory !== 8'h00) begin miscompares++; $display("FAIL reset_to_memory got %h want 00", to_memory); end
        vectors++; if ({mem_req, mem_we, stall, jmp} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctl got %b want 0000", {mem_req, mem_we, stall, jmp}); end
        vectors++; if (to_pc !== 10'h000) begin miscompares++; $display("FAIL reset_to_pc got %h want 000", to_pc); end
        vectors++; if (ctr_word_to_writeback !== 5'h00) begin miscompares++; $display("FAIL reset_wb_ctrl got %h want 00", ctr_word_to_writeback); end
        vectors++; if ({cs_overflow, cs_underflow} !== 2'b00) begin miscompares++; $display("FAIL reset_cs_flags got %b want 00", {cs_overflow, cs_underflow}); end
        wb_we = 1'b0; ctr_word_in = '0; rs1 = '0; rs2 = '0; imm = '0; target = '0; pc_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding;
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 8'h2A;
        issue(cw(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h05, 4'd3, 8'h07, 4'd3, 8'h01, 10'h0, 2'b00, 10'h0);
        vectors++; if (alu_res !== 8'h2B) begin miscompares++; $display("FAIL fwd_rs1 got %h want 2b", alu_res); end
        vectors++; if (to_memory !== 8'h2A) begin miscompares++; $display("FAIL fwd_rs2 got %h want 2a", to_memory); end
        wb_we = 1'b0;
        #1;
        vectors++; if (alu_res !== 8'h06) begin miscompares++; $display("FAIL nofwd_rs1 got %h want 06", alu_res); end
        vectors++; if (to_memory !== 8'h07) begin miscompares++; $display("FAIL nofwd_rs2 got %h want 07", to_memory); end
        wb_we = 1'b1; wb_addr = 4'd0;
        issue(cw(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h05, 4'd0, 8'h07, 4'd5, 8'h01, 10'h0, 2'b00, 10'h0);
        vectors++; if (alu_res !== 8'h01) begin miscompares++; $display("FAIL fwd_r0 got %h want 01", alu_res); end
        vectors++; if (to_memory !== 8'h07) begin miscompares++; $display("FAIL fwd_r0_rs2 got %h want 07", to_memory); end
        wb_we = 1'b0;
    endtask

    task automatic test_alu_ops;
        logic [2:0] ops [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        logic [7:0] av  [6] = '{8'h05, 8'hF0, 8'hF0, 8'hF0, 8'h81, 8'h00};
        logic [7:0] bv  [6] = '{8'h07, 8'h0C, 8'h3C, 8'h3C, 8'h00, 8'h5A};
        logic [7:0] ev  [6] = '{8'hFE, 8'h03, 8'h30, 8'hCC, 8'h40, 8'h5A};
        for (int i = 0; i < 6; i++) begin
            issue(cw(ops[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
                  av[i], 4'd1, 8'h00, 4'd2, bv[i], 10'h0, 2'b00, 10'h0);
            vectors++; if (alu_res !== ev[i]) begin miscompares++; $display("FAIL alu_op%0d got %h want %h", ops[i], alu_res, ev[i]); end
        end
    endtask

    task automatic test_adc_chain;
        issue(cw(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'hFF, 4'd1, 8'h00, 4'd2, 8'h01, 10'h0, 2'b00, 10'h0);
        vectors++; if (alu_res !== 8'h00) begin miscompares++; $display("FAIL adc_first_add got %h want 00", alu_res); end
        issue(cw(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h10, 4'd1, 8'h00, 4'd2, 8'h00, 10'h0, 2'b00, 10'h0);
        vectors++; if (alu_res !== 8'h11) begin miscompares++; $display("FAIL adc_carry_in got %h want 11", alu_res); end
    endtask

    // Flags arrive here as C=1, Z=1 from the ADD that overflowed in test_adc_chain.
    task automatic test_branch;
        logic [17:0] br;
        br = cw(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        issue(br, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h155, 2'b00, 10'h0);
        vectors++; if (jmp !== 1'b1) begin miscompares++; $display("FAIL br_z_taken got %b want 1", jmp); end
        vectors++; if (to_pc !== 10'h155) begin miscompares++; $display("FAIL br_target got %h want 155", to_pc); end
        issue(br, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h155, 2'b01, 10'h0);
        vectors++; if (jmp !== 1'b0) begin miscompares++; $display("FAIL br_notz got %b want 0", jmp); end
        issue(br, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h155, 2'b10, 10'h0);
        vectors++; if (jmp !== 1'b1) begin miscompares++; $display("FAIL br_c_set got %b want 1", jmp); end
        issue(cw(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h01, 4'd1, 8'h00, 4'd0, 8'h01, 10'h0, 2'b00, 10'h0);
        issue(br, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h0AA, 2'b10, 10'h0);
        vectors++; if (jmp !== 1'b0) begin miscompares++; $display("FAIL br_c_clear got %b want 0", jmp); end
        issue(br, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h0AA, 2'b11, 10'h0);
        vectors++; if (jmp !== 1'b1) begin miscompares++; $display("FAIL br_notc got %b want 1", jmp); end
        issue(br, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h0AA, 2'b00, 10'h0);
        vectors++; if (jmp !== 1'b0) begin miscompares++; $display("FAIL br_z_clear got %b want 0", jmp); end
        issue(cw(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h81, 4'd1, 8'h00, 4'd0, 8'h00, 10'h0, 2'b00, 10'h0);
        issue(br, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h0AA, 2'b10, 10'h0);
        vectors++; if (jmp !== 1'b1) begin miscompares++; $display("FAIL br_rsh_carry got %b want 1", jmp); end
        issue(cw(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h2AA, 2'b00, 10'h0);
        vectors++; if ({jmp, to_pc} !== {1'b1, 10'h2AA}) begin miscompares++; $display("FAIL uncond_jmp got %b/%h want 1/2aa", jmp, to_pc); end
    endtask

    task automatic test_mem_stall;
        mem_ready = 1'b0;
        issue(cw(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h15),
              8'h00, 4'd1, 8'h77, 4'd2, 8'h00, 10'h0, 2'b00, 10'h0);
        ctr_word_in = cw(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        rs1 = 8'h00; imm = 8'h33; rs2 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({stall, mem_req, mem_we} !== 3'b111) begin miscompares++; $display("FAIL stall_hs cyc%0d got %b want 111", i, {stall, mem_req, mem_we}); end
            vectors++; if ({jmp, ctr_word_to_writeback} !== 6'h00) begin miscompares++; $display("FAIL stall_mask cyc%0d got %b/%h want 0/00", i, jmp, ctr_word_to_writeback); end
            vectors++; if ({to_memory, alu_res} !== 16'h7777) begin miscompares++; $display("FAIL stall_hold cyc%0d got %h/%h want 77/77", i, to_memory, alu_res); end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        #1;
        vectors++; if ({stall, mem_req, jmp} !== 3'b011) begin miscompares++; $display("FAIL stall_release got %b want 011", {stall, mem_req, jmp}); end
        vectors++; if (ctr_word_to_writeback !== 5'h15) begin miscompares++; $display("FAIL release_wb_ctrl got %h want 15", ctr_word_to_writeback); end
        @(posedge clk);
        #1;
        vectors++; if ({alu_res, mem_req} !== {8'h33, 1'b0}) begin miscompares++; $display("FAIL next_captured got %h/%b want 33/0", alu_res, mem_req); end
    endtask

    task automatic test_flush;
        issue(cw(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h40, 4'd1, 8'h00, 4'd0, 8'h02, 10'h0, 2'b00, 10'h0);
        clk_en = 1'b0;
        issue(cw(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h10, 4'd1, 8'h00, 4'd0, 8'h02, 10'h0, 2'b00, 10'h0);
        vectors++; if (alu_res !== 8'h42) begin miscompares++; $display("FAIL clk_en_hold got %h want 42", alu_res); end
        clk_en = 1'b1; flush = 1'b1;
        issue(cw(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'h0F),
              8'h10, 4'd1, 8'h00, 4'd0, 8'h02, 10'h123, 2'b00, 10'h0);
        flush = 1'b0;
        #1;
        vectors++; if ({alu_res, mem_req, jmp, ctr_word_to_writeback} !== 15'h0) begin miscompares++; $display("FAIL flush_bubble got %h/%b/%b/%h want 00/0/0/00", alu_res, mem_req, jmp, ctr_word_to_writeback); end
    endtask

    task automatic test_call_stack;
        logic [17:0] push_w, pop_w;
        logic [9:0]  exp_pc [5] = '{10'h005, 10'h004, 10'h003, 10'h002, 10'h000};
        push_w = cw(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00);
        pop_w  = cw(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00);
        for (int i = 1; i <= 5; i++)
            issue(push_w, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h0, 2'b00, 10'(i));
        vectors++; if (cs_overflow !== 1'b0) begin miscompares++; $display("FAIL cs_ovf_early got %b want 0", cs_overflow); end
        for (int i = 0; i < 5; i++) begin
            issue(pop_w, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h3FF, 2'b00, 10'h0);
            vectors++; if (to_pc !== exp_pc[i]) begin miscompares++; $display("FAIL cs_pop%0d got %h want %h", i, to_pc, exp_pc[i]); end
        end
        vectors++; if ({cs_overflow, cs_underflow} !== 2'b10) begin miscompares++; $display("FAIL cs_flags_pre got %b want 10", {cs_overflow, cs_underflow}); end
        issue('0, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h0, 2'b00, 10'h0);
        vectors++; if ({cs_overflow, cs_underflow} !== 2'b11) begin miscompares++; $display("FAIL cs_underflow got %b want 11", {cs_overflow, cs_underflow}); end
    endtask

    task automatic test_reset_mid_stall;
        mem_ready = 1'b0;
        issue(cw(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0A),
              8'h12, 4'd1, 8'h34, 4'd2, 8'h00, 10'h0, 2'b00, 10'h0);
        vectors++; if ({stall, alu_res} !== {1'b1, 8'h46}) begin miscompares++; $display("FAIL pre_reset_stall got %b/%h want 1/46", stall, alu_res); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({stall, mem_req, mem_we, jmp} !== 4'b0000) begin miscompares++; $display("FAIL async_reset_ctl got %b want 0000", {stall, mem_req, mem_we, jmp}); end
        vectors++; if ({alu_res, to_memory, to_pc} !== 26'h0) begin miscompares++; $display("FAIL async_reset_data got %h/%h/%h want 0", alu_res, to_memory, to_pc); end
        vectors++; if ({cs_overflow, cs_underflow} !== 2'b00) begin miscompares++; $display("FAIL async_reset_sticky got %b want 00", {cs_overflow, cs_underflow}); end
        mem_ready = 1'b1; ctr_word_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(cw(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00),
              8'h10, 4'd1, 8'h00, 4'd0, 8'h00, 10'h0, 2'b00, 10'h0);
        vectors++; if (alu_res !== 8'h10) begin miscompares++; $display("FAIL post_reset_carry got %h want 10", alu_res); end
        issue(cw(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'h00),
              8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h3FF, 2'b00, 10'h0);
        vectors++; if (to_pc !== 10'h000) begin miscompares++; $display("FAIL post_reset_top got %h want 000", to_pc); end
        issue('0, 8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 10'h0, 2'b00, 10'h0);
        vectors++; if (cs_underflow !== 1'b1) begin miscompares++; $display("FAIL post_reset_empty got %b want 1", cs_underflow); end
    endtask

    initial begin
        test_reset;
        test_forwarding;
        test_alu_ops;
        test_adc_chain;
        test_branch;
        test_mem_stall;
        test_flush;
        test_call_stack;
        test_reset_mid_stall;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
